// File: rtl/controlador_bus_rtc.sv
`default_nettype none
// ============================================================================
// Module   : controlador_bus_rtc
// Purpose  : Runs one multiplexed address/data RTC bus cycle per request
//            edge and returns read data and status to the PicoBlaze.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_bus_rtc #(
  parameter int T_PULSE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       contro_escribe,
  input  logic       contro_lee,
  input  logic [7:0] Dir,
  input  logic [7:0] Dato,
  input  logic [7:0] Port_ID,
  input  logic       Read_Strobe,
  output logic [7:0] In_Port,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [7:0] C_LAST = 8'(T_PULSE - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_REC  = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_nxt_state;
  logic [7:0] r_cnt;
  logic       r_esc_q;
  logic       r_lee_q;
  logic       r_op_wr;
  logic [7:0] r_dato;
  logic [7:0] r_dato_leido;
  logic       r_done;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_ad_n;
  logic       r_ad_oe;
  logic [7:0] r_ad_out;

  logic       w_req_wr;
  logic       w_req_rd;
  logic       w_accept;
  logic       w_phase_end;
  logic       w_busy;
  logic       w_clr_done;

  // Only rising edges start a cycle; a write edge beats a simultaneous read.
  assign w_req_wr    = contro_escribe & ~r_esc_q;
  assign w_req_rd    = contro_lee & ~r_lee_q;
  assign w_accept    = (r_state == S_IDLE) & (w_req_wr | w_req_rd);
  assign w_phase_end = (r_cnt == C_LAST);
  assign w_busy      = (r_state != S_IDLE);
  assign w_clr_done  = Read_Strobe & (Port_ID == 8'h06);

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept)    w_nxt_state = S_ADDR;
      S_ADDR: if (w_phase_end) w_nxt_state = S_GAP;
      S_GAP:  if (w_phase_end) w_nxt_state = S_DATA;
      S_DATA: if (w_phase_end) w_nxt_state = S_REC;
      S_REC:  if (w_phase_end) w_nxt_state = S_IDLE;
      default:                 w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'h00;
      r_esc_q      <= 1'b0;
      r_lee_q      <= 1'b0;
      r_op_wr      <= 1'b0;
      r_dato       <= 8'h00;
      r_dato_leido <= 8'h00;
      r_done       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_ad_n       <= 1'b1;
      r_ad_oe      <= 1'b0;
      r_ad_out     <= 8'h00;
    end else begin
      r_esc_q <= contro_escribe;
      r_lee_q <= contro_lee;
      r_state <= w_nxt_state;

      if ((r_state == S_IDLE) || w_phase_end) r_cnt <= 8'h00;
      else                                    r_cnt <= r_cnt + 8'h01;

      if (w_accept) begin
        r_op_wr <= w_req_wr;
        r_dato  <= Dato;
      end

      if ((r_state == S_DATA) && w_phase_end && !r_op_wr) r_dato_leido <= ad_in;

      // Strobes come from the next state so pins change on the same edge as the FSM.
      r_cs_n  <= 1'b1;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_ad_n  <= 1'b1;
      r_ad_oe <= 1'b0;
      case (w_nxt_state)
        S_ADDR: begin
          r_cs_n  <= 1'b0;
          r_wr_n  <= 1'b0;
          r_ad_n  <= 1'b0;
          r_ad_oe <= 1'b1;
        end
        S_DATA: begin
          r_cs_n  <= 1'b0;
          r_wr_n  <= ~r_op_wr;
          r_rd_n  <= r_op_wr;
          r_ad_oe <= r_op_wr;
        end
        default: ;
      endcase

      if (w_accept) r_ad_out <= Dir;
      else if ((r_state == S_GAP) && w_phase_end && r_op_wr) r_ad_out <= r_dato;

      // A clear in the same cycle wins over both acceptance and completion.
      if ((r_state == S_REC) && w_phase_end) r_done <= 1'b1;
      if (w_accept || w_clr_done)            r_done <= 1'b0;
    end
  end

  always_comb begin
    In_Port = 8'h00;
    if (Port_ID == 8'h06)      In_Port = r_dato_leido;
    else if (Port_ID == 8'h07) In_Port = {6'b0, r_done, w_busy};
  end

  assign cs_n   = r_cs_n;
  assign rd_n   = r_rd_n;
  assign wr_n   = r_wr_n;
  assign ad_n   = r_ad_n;
  assign ad_oe  = r_ad_oe;
  assign ad_out = r_ad_out;

endmodule
`default_nettype wire

// File: doc/controlador_bus_rtc.md
# controlador_bus_rtc

Bus-cycle engine on the far side of the PicoBlaze output registers. It consumes the write/read requests, address and data latched from the processor (`Dir`, `Dato`, `contro_escribe`, `contro_lee`) and runs one multiplexed address/data cycle on the RTC parallel bus. It returns read data and status to the processor input port (`In_Port`) through a `Port_ID`/`Read_Strobe` mux.

## Interface
Parameters:
- `T_PULSE`, default 8: clock cycles per bus phase; legal range 1..255 (8-bit phase counter).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `contro_escribe`  in  1  write request level from the output registers.
- `contro_lee`  in  1  read request level from the output registers.
- `Dir`  in  8  RTC register address.
- `Dato`  in  8  write data.
- `Port_ID`  in  8  PicoBlaze port address.
- `Read_Strobe`  in  1  PicoBlaze read strobe.
- `In_Port`  out  8  PicoBlaze input data, combinational mux.
- `cs_n`, `rd_n`, `wr_n`  out  1  RTC chip select, read strobe and write strobe, all active-low.
- `ad_n`  out  1  A/D select: 0 = address phase, 1 = data phase.
- `ad_out`  out  8  value driven onto the AD bus.
- `ad_oe`  out  1  AD bus output enable; the top level builds the tristate.
- `ad_in`  in  8  AD bus sampled value.

## Operation
- **Request detect:** registers `esc_q` and `lee_q` hold the previous `contro_escribe` and `contro_lee`. A request is a rising edge, `x & ~x_q`. Levels alone never start a cycle.
- **Request handling:**
  - A request is accepted only in IDLE. Edges that arrive while busy are dropped.
  - If write and read edges arrive in the same cycle, the write wins and the read is dropped.
  - On acceptance, `Dir`, `Dato` and the operation (write or read) are latched, and `done` is cleared.
- **FSM states** (each non-IDLE state lasts exactly `T_PULSE` cycles, counted by the phase counter):
  - IDLE: `cs_n=rd_n=wr_n=ad_n=1`, `ad_oe=0`. Leaves to ADDR on an accepted request.
  - ADDR: `cs_n=0`, `wr_n=0`, `ad_n=0`, `ad_oe=1`, `ad_out`=latched `Dir`.
  - GAP: all strobes high, `ad_n=1`, `ad_oe=0`.
  - DATA, write: `cs_n=0`, `wr_n=0`, `ad_oe=1`, `ad_out`=latched `Dato`.
  - DATA, read: `cs_n=0`, `rd_n=0`, `ad_oe=0`. `ad_in` is captured into `dato_leido` on the last DATA cycle.
  - REC: all strobes high, `ad_oe=0`. Leaves to IDLE, setting `done=1`.
- **Status register** `{6'b0, done, busy}`: `busy` = 1 whenever the FSM is not in IDLE.
- **`In_Port` mux:**
  - `Port_ID` 0x06 → `dato_leido`.
  - `Port_ID` 0x07 → status.
  - Any other `Port_ID` → 0x00.
- **Clearing `done`:** `Read_Strobe` with `Port_ID`=0x06 clears `done` on the next edge. If an acceptance happens in the same cycle, the result is still `done=0`.
- **Reset values:**
  - `cs_n`, `rd_n`, `wr_n`, `ad_n` = 1.
  - `ad_oe` = 0, `ad_out` = 0x00.
  - `dato_leido` = 0x00, `busy` = 0, `done` = 0.
  - `esc_q` = `lee_q` = 0, state IDLE, phase counter 0.
- **Reset mid-cycle:** takes effect at the next edge. All outputs return to their reset values and the cycle is abandoned with no `done` and no `dato_leido` update.

## Timing
- All bus outputs are registered; there are no combinational paths from inputs to bus pins.
- Request edge at input → strobes asserted:
  - `contro_escribe` rises after edge E0.
  - The rise is detected at E1, which moves the FSM into ADDR.
  - `cs_n`, `wr_n` and `ad_n` are low from E1 to E1+T.
- **Phase boundaries:**
  - ADDR: E1 → E1+T.
  - GAP: E1+T → E1+2T.
  - DATA: E1+2T → E1+3T.
  - REC: E1+3T → E1+4T.
- At E1+4T: `busy`→0 and `done`→1.
- Total cycle time is 4·`T_PULSE` clocks.
- Read capture: `ad_in` sampled at edge E1+3T, i.e. the last cycle with `rd_n=0`. `dato_leido` is stable from then on.
- `ad_oe` is never 1 while `rd_n=0`. `ad_out` changes only at phase boundaries.
- The earliest a new request can be accepted is the edge after E1+4T, and it must come from a fresh rising edge.

## Test plan
All scenarios use `T_PULSE`=4.
1. **Reset check:** hold `rst` for 2 cycles → `cs_n=rd_n=wr_n=ad_n=1`, `ad_oe=0`, `In_Port`=0x00 on `Port_ID` 0x06 and on 0x07.
2. **Write cycle:** `Dir`=0x21, `Dato`=0x59, raise `contro_escribe` →
   - ADDR: 4 cycles with `ad_n=0`, `wr_n=0`, `ad_out`=0x21, `ad_oe=1`.
   - GAP: 4 idle cycles.
   - DATA: 4 cycles with `wr_n=0`, `ad_out`=0x59.
   - REC: 4 cycles.
   - Then status=0x02.
3. **Read cycle:** `Dir`=0x24, bus model returns 0xA7 while `rd_n=0`, raise `contro_lee` →
   - ADDR drives 0x24.
   - During DATA, `ad_oe=0`.
   - After 16 cycles, status=0x02 and `Port_ID` 0x06 gives 0xA7.
   - `Read_Strobe` on 0x06 → status=0x00.
4. **Simultaneous and busy requests:**
   - Raise both requests in one cycle → only a write cycle runs.
   - Toggle `contro_lee` 0→1 during that cycle → no second bus cycle.
   - `busy`=1 for exactly 16 cycles.
5. **Reset mid-read:** assert `rst` at the 2nd DATA cycle → next edge all strobes high, `ad_oe=0`, status=0x00, `dato_leido` unchanged at 0x00.
6. **Level held:** keep `contro_escribe`=1 for 40 cycles → exactly one write cycle.
